alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
//
// PURPOSE
// Shares one 32-bit gate-level ALU (module ALU) between two requesters.
// - Round-robin arbitration; each requester uses a valid/ready request and a valid/ready response.
// - Operands and command are registered and held stable for a fixed settle window, so the
//   ALU's gate-delay ripple resolves before the outputs are sampled.
// - Result and flags are registered and returned to the granted requester.
// - One operation is in flight at a time. The block is the sole driver of its ALU instance.
//
// PARAMETERS
// SETTLE_CYCLES  4  clock cycles operands are held on the ALU before sampling; legal range >= 1
//
// PORTS
// clk            in   1   clock; all state updates on the rising edge
// reset          in   1   synchronous, active-high reset
// req0_valid     in   1   requester 0 has an operation
// req0_ready     out  1   requester 0 operation accepted this cycle
// req0_a         in   32  requester 0 operand A
// req0_b         in   32  requester 0 operand B
// req0_cmd       in   3   requester 0 ALU command: 000 add, 001 sub, 011 slt, others per ALU
// req1_valid     in   1   requester 1, same meaning as requester 0
// req1_ready     out  1   requester 1, same meaning as requester 0
// req1_a         in   32  requester 1, same meaning as requester 0
// req1_b         in   32  requester 1, same meaning as requester 0
// req1_cmd       in   3   requester 1, same meaning as requester 0
// resp0_valid    out  1   response pending for requester 0
// resp0_ready    in   1   requester 0 takes the response
// resp1_valid    out  1   response pending for requester 1
// resp1_ready    in   1   requester 1 takes the response
// resp_result    out  32  registered ALU result, shared by both responses
// resp_carryout  out  1   registered ALU carryout
// resp_zero      out  1   registered ALU zero flag
// resp_overflow  out  1   registered ALU overflow flag
//
// BEHAVIOUR
// - Reset values: state IDLE, resp0_valid=0, resp1_valid=0, resp_result=0, all flags 0,
//   operand/command regs 0, settle counter 0, last_grant=1 (requester 0 has priority first).
// - States: IDLE -> EXEC -> RESP -> IDLE.
// - reqN_ready is combinational and asserts only in IDLE:
//   - req0_ready = IDLE & req0_valid & (!req1_valid | last_grant==1)
//   - req1_ready = IDLE & req1_valid & (!req0_valid | last_grant==0)
//   - At most one ready is high in any cycle.
// - Accept (IDLE, ready & valid):
//   - Capture that requester's a/b/cmd into the operand regs.
//   - Set owner and last_grant to the granted requester.
//   - Load counter = SETTLE_CYCLES-1, go to EXEC.
// - Requests are never dropped: an unaccepted request waits until granted.
// - EXEC: ALU inputs come from the operand regs only; request inputs are ignored.
//   - counter != 0: decrement.
//   - counter == 0: register ALU result/carryout/zero/overflow, set resp<owner>_valid, go to RESP.
// - Latency: accept on edge 0 -> respN_valid high from cycle SETTLE_CYCLES+1.
//   Default: 5 cycles.
// - RESP: resp_* and the owner's respN_valid hold stable until respN_ready=1.
//   - On that edge: clear respN_valid, go to IDLE.
//   - No new grant in the same cycle.
//   - Minimum issue interval: SETTLE_CYCLES+2 cycles.
// - The non-owner's respN_ready is ignored.
// - Both responses are never valid together.
// - Flags are passed through unmodified. The ALU already forces carryout/zero/overflow to 0
//   for non-add/sub commands; no further masking here.
// - Round robin: with both requesters continuously valid, grants alternate 0,1,0,1...
//   A lone requester is granted every slot regardless of last_grant.
// - Reset mid-operation, in any state:
//   - Next state is IDLE and the in-flight op is discarded; no response is ever issued for it.
//   - last_grant returns to 1.
//   - A requester still asserting valid is re-granted normally.
//
// TESTING
// - T1: reset 2 cycles; req0 add A=5 B=7 cmd=000, resp0_ready=1 -> req0_ready in cycle 0;
//   resp0_valid in cycle 5; result=12, carry=0, zero=0, ovf=0.
// - T2: req1 sub A=7 B=7 cmd=001 -> result=0, zero=1; req1 slt A=0xFFFFFFFF B=1 cmd=011 ->
//   result=1, flags all 0.
// - T3: req0 add 0x7FFFFFFF+1 -> result=0x80000000, ovf=1, carry=0; req0 add 0xFFFFFFFF+1 ->
//   result=0, carry=1, zero=1, ovf=0.
// - T4: both valid from reset, 4 ops each, resp ready=1 -> grant order 0,1,0,1,0,1,0,1;
//   new accept every 6 cycles; each response matches its operands.
// - T5: resp0_ready held 0 for 10 cycles with req1 valid -> resp0_valid and resp_* stable;
//   req1_ready=0 throughout; req1 granted the cycle after the resp0 handshake.
// - T6: reset asserted in cycle 2 of EXEC with req0 still valid -> IDLE next cycle;
//   no resp0_valid for the aborted op; req0 re-accepted; correct result 5 cycles later.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ALU / alu_arbiter
// Purpose  : alu_arbiter shares one 32-bit ALU between two requesters. It uses
//            round-robin arbitration with valid/ready requests and valid/ready
//            responses. Operands are held on the ALU for SETTLE_CYCLES so the
//            ripple logic resolves. The result and flags are then registered
//            and returned to the requester that was granted.
// Ports    : clk, reset (sync, active-high)
//            req0_*/req1_*   : valid/ready request with a, b, cmd
//            resp0_*/resp1_* : valid/ready response
//            resp_result/carryout/zero/overflow : shared registered response
// Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// ALU: 32-bit combinational ALU.
// Commands: 000 add, 001 sub, 010 xor, 011 slt, 100 and, 101 nand, 110 nor,
// 111 or. Carryout, zero and overflow are valid only for add/sub and are
// forced to 0 for every other command.
// ----------------------------------------------------------------------------
module ALU (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_command,
    output logic [31:0] o_result,
    output logic        o_carryout,
    output logic        o_zero,
    output logic        o_overflow
);
    localparam logic [2:0] c_add  = 3'b000;
    localparam logic [2:0] c_sub  = 3'b001;
    localparam logic [2:0] c_xor  = 3'b010;
    localparam logic [2:0] c_slt  = 3'b011;
    localparam logic [2:0] c_and  = 3'b100;
    localparam logic [2:0] c_nand = 3'b101;
    localparam logic [2:0] c_nor  = 3'b110;

    logic        w_is_sub;
    logic [31:0] w_b_eff;
    logic [32:0] w_sum;
    logic        w_ovf;
    logic        w_slt;

    // Subtraction and slt share the adder as a + ~b + 1.
    assign w_is_sub = (i_command == c_sub) || (i_command == c_slt);
    assign w_b_eff  = w_is_sub ? ~i_b : i_b;
    assign w_sum    = {1'b0, i_a} + {1'b0, w_b_eff} + {32'd0, w_is_sub};
    assign w_ovf    = (i_a[31] == w_b_eff[31]) && (w_sum[31] != i_a[31]);
    // Signed less-than: the sign of the difference, corrected when it overflowed.
    assign w_slt    = w_sum[31] ^ w_ovf;

    always_comb begin
        o_result   = 32'd0;
        o_carryout = 1'b0;
        o_zero     = 1'b0;
        o_overflow = 1'b0;
        case (i_command)
            c_add, c_sub: begin
                o_result   = w_sum[31:0];
                o_carryout = w_sum[32];
                o_overflow = w_ovf;
                o_zero     = (w_sum[31:0] == 32'd0);
            end
            c_xor:   o_result = i_a ^ i_b;
            c_slt:   o_result = {31'd0, w_slt};
            c_and:   o_result = i_a & i_b;
            c_nand:  o_result = ~(i_a & i_b);
            c_nor:   o_result = ~(i_a | i_b);
            default: o_result = i_a | i_b;
        endcase
    end
endmodule

// ----------------------------------------------------------------------------
// alu_arbiter: top level
// ----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_cmd,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_cmd,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp_result,
    output logic        resp_carryout,
    output logic        resp_zero,
    output logic        resp_overflow
);
    localparam int                c_cnt_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_load = c_cnt_w'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               r_state;
    logic [31:0]          r_a;
    logic [31:0]          r_b;
    logic [2:0]           r_cmd;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_owner;
    logic                 r_last_grant;

    logic [31:0]          w_alu_result;
    logic                 w_alu_carry;
    logic                 w_alu_zero;
    logic                 w_alu_ovf;
    logic                 w_resp_take;

    // The ALU only ever sees the operand registers, so the request inputs
    // cannot disturb an operation that is settling.
    ALU u_alu (
        .i_a        (r_a),
        .i_b        (r_b),
        .i_command  (r_cmd),
        .o_result   (w_alu_result),
        .o_carryout (w_alu_carry),
        .o_zero     (w_alu_zero),
        .o_overflow (w_alu_ovf)
    );

    // Round robin: when both requesters are valid, the one not granted last
    // time wins. A lone requester wins regardless of history.
    assign req0_ready = (r_state == IDLE) && req0_valid && (!req1_valid || r_last_grant);
    assign req1_ready = (r_state == IDLE) && req1_valid && (!req0_valid || !r_last_grant);

    // Only the owner's response ready is honoured.
    assign w_resp_take = r_owner ? resp1_ready : resp0_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_a           <= 32'd0;
            r_b           <= 32'd0;
            r_cmd         <= 3'd0;
            r_count       <= '0;
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b1;
            resp0_valid   <= 1'b0;
            resp1_valid   <= 1'b0;
            resp_result   <= 32'd0;
            resp_carryout <= 1'b0;
            resp_zero     <= 1'b0;
            resp_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req0_ready) begin
                        r_a          <= req0_a;
                        r_b          <= req0_b;
                        r_cmd        <= req0_cmd;
                        r_owner      <= 1'b0;
                        r_last_grant <= 1'b0;
                        r_count      <= c_load;
                        r_state      <= EXEC;
                    end else if (req1_ready) begin
                        r_a          <= req1_a;
                        r_b          <= req1_b;
                        r_cmd        <= req1_cmd;
                        r_owner      <= 1'b1;
                        r_last_grant <= 1'b1;
                        r_count      <= c_load;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_count != '0) begin
                        r_count <= r_count - 1'b1;
                    end else begin
                        resp_result   <= w_alu_result;
                        resp_carryout <= w_alu_carry;
                        resp_zero     <= w_alu_zero;
                        resp_overflow <= w_alu_ovf;
                        resp0_valid   <= !r_owner;
                        resp1_valid   <= r_owner;
                        r_state       <= RESP;
                    end
                end
                RESP: begin
                    // Returning to IDLE here means the next grant happens
                    // one cycle after the handshake, never in the same cycle.
                    if (w_resp_take) begin
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter. Each requester is a queue
//            of operations. A transaction-level model predicts the grants,
//            the response timing and the ALU results.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;
    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_cmd = '0, req1_cmd = '0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [31:0] resp_result;
    logic        resp_carryout, resp_zero, resp_overflow;

    always #5 clk = ~clk;

    alu_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cmd(req0_cmd),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cmd(req1_cmd),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_carryout(resp_carryout),
        .resp_zero(resp_zero), .resp_overflow(resp_overflow)
    );

    typedef struct packed { logic [31:0] a; logic [31:0] b; logic [2:0] cmd; } op_t;
    typedef struct packed { logic [31:0] result; logic carry; logic zero; logic ovf; } res_t;

    op_t  q0[$];
    op_t  q1[$];
    int   checks = 0;
    int   errors = 0;
    bit   busy = 1'b0;
    bit   owner = 1'b0;
    bit   last = 1'b1;
    bit   prev_rst = 1'b1;
    op_t  inflight;
    res_t expect_res;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   grants[$];
    int   accept_times[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference ALU from plain integer arithmetic.
    function automatic res_t ref_alu(input op_t o);
        res_t   r;
        longint sa, sb, s, ua, ub;
        sa = longint'($signed(o.a));
        sb = longint'($signed(o.b));
        ua = longint'(o.a);
        ub = longint'(o.b);
        r  = '0;
        case (o.cmd)
            3'd0: begin
                s = sa + sb;
                r.result = o.a + o.b;
                r.carry  = (ua + ub) >= 64'sd4294967296;
                r.ovf    = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                r.zero   = (r.result == 32'd0);
            end
            3'd1: begin
                s = sa - sb;
                r.result = o.a - o.b;
                r.carry  = (o.a >= o.b);
                r.ovf    = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                r.zero   = (r.result == 32'd0);
            end
            3'd2: r.result = o.a ^ o.b;
            3'd3: r.result = (sa < sb) ? 32'd1 : 32'd0;
            3'd4: r.result = o.a & o.b;
            3'd5: r.result = ~(o.a & o.b);
            3'd6: r.result = ~(o.a | o.b);
            default: r.result = o.a | o.b;
        endcase
        return r;
    endfunction

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        op_t o;
        o.a = a; o.b = b; o.cmd = c;
        return o;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'hFFFF_FFFF;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic cycle(input bit rst_in, input bit rdy0, input bit rdy1);
        bit v0, v1, er0, er1, ev;
        @(negedge clk);
        reset = rst_in;
        v0 = (q0.size() > 0);
        v1 = (q1.size() > 0);
        req0_valid = v0;
        req1_valid = v1;
        if (v0) begin req0_a = q0[0].a; req0_b = q0[0].b; req0_cmd = q0[0].cmd; end
        else begin req0_a = $urandom; req0_b = $urandom; req0_cmd = 3'($urandom); end
        if (v1) begin req1_a = q1[0].a; req1_b = q1[0].b; req1_cmd = q1[0].cmd; end
        else begin req1_a = $urandom; req1_b = $urandom; req1_cmd = 3'($urandom); end
        resp0_ready = rdy0;
        resp1_ready = rdy1;
        #1;
        if (rst_in) begin
            // An aborted op is re-presented by its requester.
            if (busy) begin
                if (owner) q1.push_front(inflight);
                else       q0.push_front(inflight);
            end
            busy = 1'b0;
            last = 1'b1;
        end else begin
            if (prev_rst) begin
                check_val("rst_result", resp_result, 32'd0);
                check_val("rst_flags", 32'({resp_carryout, resp_zero, resp_overflow}), 32'd0);
            end
            er0 = !busy && v0 && (!v1 || last);
            er1 = !busy && v1 && (!v0 || !last);
            ev  = busy && (cyc >= acc_cyc + SETTLE + 1);
            check_val("req0_ready", 32'(req0_ready), 32'(er0));
            check_val("req1_ready", 32'(req1_ready), 32'(er1));
            check_val("resp0_valid", 32'(resp0_valid), 32'(ev && !owner));
            check_val("resp1_valid", 32'(resp1_valid), 32'(ev && owner));
            if (ev) begin
                check_val("resp_result", resp_result, expect_res.result);
                check_val("resp_flags", 32'({resp_carryout, resp_zero, resp_overflow}),
                          32'({expect_res.carry, expect_res.zero, expect_res.ovf}));
            end
            if (ev && (owner ? rdy1 : rdy0)) begin
                busy = 1'b0;
            end else if (er0 || er1) begin
                inflight   = er0 ? q0.pop_front() : q1.pop_front();
                owner      = er1;
                last       = er1;
                busy       = 1'b1;
                acc_cyc    = cyc;
                expect_res = ref_alu(inflight);
                grants.push_back(int'(er1));
                accept_times.push_back(cyc);
            end
        end
        prev_rst = rst_in;
        cyc++;
    endtask

    task automatic run_n(input int n, input bit rst_in, input bit rdy0, input bit rdy1);
        for (int i = 0; i < n; i++) cycle(rst_in, rdy0, rdy1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((busy || q0.size() != 0 || q1.size() != 0) && n < 2000) begin
            cycle(1'b0, 1'b1, 1'b1);
            n++;
        end
        run_n(2, 1'b0, 1'b1, 1'b1);
        check_val({tag, "_drain"}, 32'(busy || q0.size() != 0 || q1.size() != 0), 32'd0);
    endtask

    initial begin
        // T1: reset, then a simple add on requester 0
        run_n(2, 1'b1, 1'b0, 1'b0);
        q0.push_back(mk(32'd5, 32'd7, 3'b000));
        drain("t1");

        // T2: sub to zero and signed slt on requester 1
        q1.push_back(mk(32'd7, 32'd7, 3'b001));
        q1.push_back(mk(32'hFFFF_FFFF, 32'd1, 3'b011));
        drain("t2");

        // T3: signed overflow and unsigned carry
        q0.push_back(mk(32'h7FFF_FFFF, 32'd1, 3'b000));
        q0.push_back(mk(32'hFFFF_FFFF, 32'd1, 3'b000));
        drain("t3");

        // T4: both requesters continuously valid from reset
        run_n(2, 1'b1, 1'b1, 1'b1);
        grants.delete();
        accept_times.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk($urandom, $urandom, 3'($urandom)));
            q1.push_back(mk($urandom, $urandom, 3'($urandom)));
        end
        drain("t4");
        check_val("t4_grant_count", 32'(grants.size()), 32'd8);
        for (int i = 0; i < grants.size(); i++) begin
            check_val("t4_grant_order", 32'(grants[i]), 32'(i % 2));
            if (i > 0)
                check_val("t4_issue_gap", 32'(accept_times[i] - accept_times[i-1]), 32'(SETTLE + 2));
        end

        // T5: requester 0 withholds its response ready while requester 1 waits
        run_n(1, 1'b1, 1'b0, 1'b0);
        q0.push_back(mk(32'h1234_5678, 32'h0F0F_0F0F, 3'b010));
        cycle(1'b0, 1'b0, 1'b1);
        q1.push_back(mk(32'd100, 32'd200, 3'b001));
        run_n(SETTLE + 11, 1'b0, 1'b0, 1'b1);
        drain("t5");

        // T6: reset during EXEC with requester 0 still valid
        run_n(1, 1'b1, 1'b0, 1'b0);
        q0.push_back(mk(32'd40, 32'd2, 3'b000));
        run_n(3, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        drain("t6");

        // Randomized traffic with random response back-pressure and resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0 && q0.size() < 3)
                q0.push_back(mk(rand_word(), rand_word(), 3'($urandom)));
            if ($urandom_range(0, 3) == 0 && q1.size() < 3)
                q1.push_back(mk(rand_word(), rand_word(), 3'($urandom)));
            cycle(($urandom_range(0, 79) == 0), 1'($urandom), 1'($urandom));
        end
        drain("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
